// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad one column at a time, debounces the
// press and the release, and reports every accepted key exactly once.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset
//   rows[3:0]      in   keypad rows, active-low, asynchronous to clk
//   cols[3:0]      out  column drive, one-cold
//   clickedMatrix  out  code of the last accepted key, held until the next one
//   rec_num        out  one-cycle strobe: accepted key is a digit (0-9)
//   rec_op         out  one-cycle strobe: accepted key is an operator (A-F)
//   dbg_state_o    out  current FSM state (SCAN/DEBOUNCE/EMIT/RELEASE)
//
// Interface semantics: rec_num/rec_op are fire-and-forget strobes with no
// back-pressure. A strobe is high for exactly one cycle, never both at once,
// and clickedMatrix already carries the matching code in that same cycle.
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] clickedMatrix,
    output logic       rec_num,
    output logic       rec_op,
    output logic [1:0] dbg_state_o
);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_EMIT     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE);

    // Row-position/column-position to key code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] code;
        case ({r, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    logic [3:0]       sync1_q;
    logic [3:0]       rs_q;
    logic [1:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       col_q, col_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       code_q, code_d;
    logic             num_q, num_d;
    logic             op_q, op_d;

    logic             tick;
    logic             any_low;
    logic [1:0]       low_idx;
    logic [CNT_W-1:0] cnt_inc;
    logic [3:0]       new_code;

    assign tick     = (div_q == DIV_LAST);
    assign any_low  = ~&rs_q;
    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign new_code = key_code(row_q, col_q);

    // Lowest-numbered low row wins when several rows are pressed together.
    always_comb begin
        low_idx = 2'd3;
        if (!rs_q[2]) low_idx = 2'd2;
        if (!rs_q[1]) low_idx = 2'd1;
        if (!rs_q[0]) low_idx = 2'd0;
    end

    always_comb begin
        state_d = state_q;
        div_d   = tick ? '0 : div_q + DIV_W'(1);
        col_d   = col_q;
        row_d   = row_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        num_d   = 1'b0;
        op_d    = 1'b0;

        case (state_q)
            ST_SCAN: begin
                if (tick) begin
                    if (any_low) begin
                        row_d   = low_idx;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (tick) begin
                    if (!rs_q[row_q]) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            // The outputs are registered, so they are loaded on
                            // the edge that enters EMIT and are visible for the
                            // whole (single) EMIT cycle.
                            state_d = ST_EMIT;
                            code_d  = new_code;
                            num_d   = (new_code <= 4'h9);
                            op_d    = (new_code >  4'h9);
                        end
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_SCAN;
                    end
                end
            end
            ST_EMIT: begin
                cnt_d   = '0;
                state_d = ST_RELEASE;
            end
            default: begin // ST_RELEASE
                if (tick) begin
                    if (&rs_q) begin
                        if (cnt_inc == CNT_DONE) begin
                            cnt_d   = '0;
                            col_d   = col_q + 2'd1;
                            state_d = ST_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end
            end
        endcase

        // Every state change restarts the sampling period from zero.
        if (state_d != state_q) begin
            div_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 4'hF;
            rs_q    <= 4'hF;
            state_q <= ST_SCAN;
            div_q   <= '0;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            cnt_q   <= '0;
            code_q  <= 4'h0;
            num_q   <= 1'b0;
            op_q    <= 1'b0;
        end else begin
            sync1_q <= rows;
            rs_q    <= sync1_q;
            state_q <= state_d;
            div_q   <= div_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            num_q   <= num_d;
            op_q    <= op_d;
        end
    end

    assign cols          = ~(4'b0001 << col_q);
    assign clickedMatrix = code_q;
    assign rec_num       = num_q;
    assign rec_op        = op_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
// A small keypad model pulls a row low whenever its pressed key's column
// is driven low, so presses behave like a real matrix.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;

  logic       clk;
  logic       rst;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] clicked_matrix;
  logic       rec_num;
  logic       rec_op;
  logic [1:0] dbg_state;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk          (clk),
    .rst          (rst),
    .rows         (rows),
    .cols         (cols),
    .clickedMatrix(clicked_matrix),
    .rec_num      (rec_num),
    .rec_op       (rec_op),
    .dbg_state_o  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- keypad model ----------------
  logic [3:0] key_col [4];  // per column: mask of pressed rows
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++)
      if (cols[c] === 1'b0) rows = rows & ~key_col[c];
  end

  // ---------------- strobe monitor ----------------
  int num_cnt = 0, op_cnt = 0;
  int both_err = 0, width_err = 0, spacing_err = 0;
  int last_cyc = 0;
  bit strobe_seen = 0, prev_strobe = 0;
  logic [3:0] last_code = 4'h0;

  always @(negedge clk) begin
    if (rec_num === 1'b1 || rec_op === 1'b1) begin
      if (rec_num === 1'b1 && rec_op === 1'b1) both_err++;
      if (prev_strobe) width_err++;
      if (strobe_seen && (cyc - last_cyc) < 2 * DEBOUNCE * SCAN_DIV) spacing_err++;
      if (rec_num === 1'b1) num_cnt++;
      else op_cnt++;
      last_code   = clicked_matrix;
      last_cyc    = cyc;
      strobe_seen = 1'b1;
      prev_strobe = 1'b1;
    end else begin
      prev_strobe = 1'b0;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // ---------------- driver helpers (no checking) ----------------
  task automatic wait_col(input int c, output bit ok);
    logic [3:0] want;
    want = ~(4'b0001 << c);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (cols === want) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_strobe(input int base, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (num_cnt + op_cnt != base) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [3:0] exp_cols;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (cols !== 4'b1110) begin
      miscompares++; $display("FAIL reset_cols got=%b exp=1110", cols);
    end
    vectors++;
    if (clicked_matrix !== 4'h0) begin
      miscompares++; $display("FAIL reset_code got=%h exp=0", clicked_matrix);
    end
    vectors++;
    if (rec_num !== 1'b0 || rec_op !== 1'b0) begin
      miscompares++; $display("FAIL reset_strobes got=%b%b exp=00", rec_num, rec_op);
    end
    vectors++;
    if (dbg_state !== 2'd0) begin
      miscompares++; $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
    for (int i = 0; i <= 16; i++) begin
      exp_cols = ~(4'b0001 << ((i / 4) % 4));
      vectors++;
      if (cols !== exp_cols) begin
        miscompares++; $display("FAIL scan_cols i=%0d got=%b exp=%b", i, cols, exp_cols);
      end
      if (i < 16) @(negedge clk);
    end
  endtask

  // Starts exactly at col 0, divider 0 (left there by test_reset).
  task automatic test_digit_press();
    int p, base_n, base_o;
    bit ok;
    p = cyc; base_n = num_cnt; base_o = op_cnt;
    key_col[1] = 4'b0010;  // key 5
    wait_strobe(base_n + base_o, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL digit_timeout got=none exp=strobe");
    end
    vectors++;
    if (last_cyc !== p + 20) begin
      miscompares++; $display("FAIL digit_latency got=%0d exp=%0d", last_cyc - p, 20);
    end
    vectors++;
    if (last_code !== 4'h5) begin
      miscompares++; $display("FAIL digit_code got=%h exp=5", last_code);
    end
    while (cyc < p + 200) @(negedge clk);
    key_col[1] = 4'b0000;
    vectors++;
    if (num_cnt !== base_n + 1 || op_cnt !== base_o) begin
      miscompares++;
      $display("FAIL digit_count got=%0d/%0d exp=%0d/%0d", num_cnt, op_cnt, base_n + 1, base_o);
    end
    for (int n = 0; n < 30 && cols === 4'b1101; n++) @(negedge clk);
    vectors++;
    if (cols !== 4'b1011 || cyc !== p + 213) begin
      miscompares++;
      $display("FAIL digit_resume got=%b@%0d exp=1011@%0d", cols, cyc - p, 213);
    end
  endtask

  task automatic press_op(input int r, input int c, input logic [3:0] code);
    int base_n, base_o;
    bit ok;
    base_n = num_cnt; base_o = op_cnt;
    key_col[c] = 4'b0001 << r;
    wait_strobe(base_n + base_o, ok);
    repeat (20) @(negedge clk);
    key_col[c] = 4'b0000;
    repeat (40) @(negedge clk);
    vectors++;
    if (!ok || op_cnt !== base_o + 1 || num_cnt !== base_n) begin
      miscompares++;
      $display("FAIL op_count key=%h got=%0d/%0d exp=%0d/%0d", code, num_cnt, op_cnt, base_n, base_o + 1);
    end
    vectors++;
    if (last_code !== code) begin
      miscompares++; $display("FAIL op_code got=%h exp=%h", last_code, code);
    end
  endtask

  task automatic test_operator();
    press_op(0, 3, 4'hA);
    press_op(3, 2, 4'hF);
    press_op(3, 0, 4'hE);
  endtask

  task automatic test_bounce();
    int c0, base;
    bit ok;
    base = num_cnt + op_cnt;
    wait_col(1, ok);
    key_col[0] = 4'b0100;  // key 7
    wait_col(0, ok);
    repeat (7) @(negedge clk);   // two low samples only
    key_col[0] = 4'b0000;
    repeat (40) @(negedge clk);
    vectors++;
    if (num_cnt + op_cnt !== base) begin
      miscompares++; $display("FAIL bounce_short got=%0d exp=%0d", num_cnt + op_cnt, base);
    end
    wait_col(2, ok);
    vectors++;
    if (!ok) begin
      miscompares++; $display("FAIL bounce_scan got=%b exp=1011", cols);
    end
    wait_col(1, ok);
    key_col[0] = 4'b0100;
    wait_col(0, ok);
    c0 = cyc;
    wait_strobe(base, ok);
    vectors++;
    if (!ok || last_cyc !== c0 + 16) begin
      miscompares++; $display("FAIL bounce_long_latency got=%0d exp=16", last_cyc - c0);
    end
    vectors++;
    if (last_code !== 4'h7 || num_cnt + op_cnt !== base + 1) begin
      miscompares++; $display("FAIL bounce_long_code got=%h exp=7", last_code);
    end
    repeat (10) @(negedge clk);
    key_col[0] = 4'b0000;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_multi_key();
    int c0, base, base_o;
    bit ok;
    base = num_cnt + op_cnt;
    wait_col(1, ok);
    key_col[0] = 4'b0110;  // r1 and r2 in col 0
    wait_col(0, ok);
    c0 = cyc;
    wait_strobe(base, ok);
    vectors++;
    if (!ok || last_cyc !== c0 + 16 || last_code !== 4'h4) begin
      miscompares++; $display("FAIL multi_code got=%h@%0d exp=4@16", last_code, last_cyc - c0);
    end
    repeat (40) @(negedge clk);
    key_col[0] = 4'b0100;  // r1 released, r2 still held
    repeat (60) @(negedge clk);
    key_col[0] = 4'b0000;
    repeat (40) @(negedge clk);
    vectors++;
    if (num_cnt + op_cnt !== base + 1 || last_code !== 4'h4) begin
      miscompares++;
      $display("FAIL multi_second_row got=%0d,%h exp=%0d,4", num_cnt + op_cnt, last_code, base + 1);
    end
    base = num_cnt + op_cnt;
    base_o = op_cnt;
    key_col[0] = 4'b0010;  // key 4
    wait_strobe(base, ok);
    key_col[3] = 4'b0001;  // key A, other column
    repeat (60) @(negedge clk);
    vectors++;
    if (num_cnt + op_cnt !== base + 1 || last_code !== 4'h4) begin
      miscompares++;
      $display("FAIL multi_masked got=%0d,%h exp=%0d,4", num_cnt + op_cnt, last_code, base + 1);
    end
    key_col[0] = 4'b0000;
    wait_strobe(base + 1, ok);
    vectors++;
    if (!ok || last_code !== 4'hA || op_cnt !== base_o + 1) begin
      miscompares++; $display("FAIL multi_after_release got=%h exp=A", last_code);
    end
    repeat (10) @(negedge clk);
    key_col[3] = 4'b0000;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_reset_mid_press();
    int c0, base_n, base_o;
    bit ok;
    base_n = num_cnt; base_o = op_cnt;
    wait_col(1, ok);
    key_col[2] = 4'b0100;  // key 9
    wait_col(2, ok);
    c0 = cyc;
    repeat (8) @(negedge clk);  // in DEBOUNCE
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (num_cnt !== base_n || op_cnt !== base_o) begin
      miscompares++; $display("FAIL midrst_early got=%0d exp=%0d", num_cnt, base_n);
    end
    vectors++;
    if (cols !== 4'b1110 || clicked_matrix !== 4'h0 || rec_num !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_values got=%b,%h,%b exp=1110,0,0", cols, clicked_matrix, rec_num);
    end
    wait_strobe(base_n + base_o, ok);
    vectors++;
    if (!ok || last_cyc !== c0 + 33) begin
      miscompares++; $display("FAIL midrst_latency got=%0d exp=33", last_cyc - c0);
    end
    vectors++;
    if (last_code !== 4'h9) begin
      miscompares++; $display("FAIL midrst_code got=%h exp=9", last_code);
    end
    repeat (100) @(negedge clk);  // still held: must not re-emit
    key_col[2] = 4'b0000;
    repeat (40) @(negedge clk);
    vectors++;
    if (num_cnt !== base_n + 1 || op_cnt !== base_o) begin
      miscompares++;
      $display("FAIL midrst_once got=%0d/%0d exp=%0d/%0d", num_cnt, op_cnt, base_n + 1, base_o);
    end
  endtask

  task automatic test_strobe_hygiene();
    vectors++;
    if (both_err !== 0) begin
      miscompares++; $display("FAIL both_strobes got=%0d exp=0", both_err);
    end
    vectors++;
    if (width_err !== 0) begin
      miscompares++; $display("FAIL strobe_width got=%0d exp=0", width_err);
    end
    vectors++;
    if (spacing_err !== 0) begin
      miscompares++; $display("FAIL strobe_spacing got=%0d exp=0", spacing_err);
    end
  endtask

  initial begin
    rst = 1'b1;
    for (int c = 0; c < 4; c++) key_col[c] = 4'b0000;
    @(negedge clk);
    test_reset();
    test_digit_press();
    test_operator();
    test_bounce();
    test_multi_key();
    test_reset_mid_press();
    test_strobe_hygiene();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
